// File: rtl/shader_loader_pkg.sv
// Shared constants for the shader loader: command bytes, FSM states, word framing.
package shader_loader_pkg;

  localparam logic [7:0] CMD_WRITE_INST = 8'h01;
  localparam logic [7:0] CMD_WRITE_DATA = 8'h02;
  localparam logic [7:0] CMD_RUN        = 8'h03;
  localparam logic [7:0] CMD_HALT       = 8'h04;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    CMD,
    ADDR_LO,
    ADDR_HI,
    COUNT,
    DATA,
    WRITE
  } state_t;

endpackage

// File: rtl/shader_loader.sv
// Host-side loader: parses a byte command stream into instruction/data RAM
// word writes and controls the core's run input.
module shader_loader
  import shader_loader_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned WORD_WIDTH    = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ADDRESS_WIDTH-1:0] inst_ext_address,
  output logic [WORD_WIDTH-1:0]    inst_ext_in_data,
  output logic                     inst_ext_write,
  output logic [ADDRESS_WIDTH-1:0] data_ext_address,
  output logic [WORD_WIDTH-1:0]    data_ext_in_data,
  output logic                     data_ext_write,
  output logic                     run,
  output logic                     busy,
  output logic                     error
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_t                   state;
  state_t                   next_state;
  logic                     accept;
  logic                     sel_data;
  logic [7:0]               addr_lo;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [8:0]               remaining;
  logic [23:0]              shift;
  logic [1:0]               idx;

  assign accept         = in_valid & in_ready;
  assign in_ready       = (state != WRITE);
  assign busy           = (state != CMD);
  assign inst_ext_write = (state == WRITE) & ~sel_data;
  assign data_ext_write = (state == WRITE) &  sel_data;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= CMD;
    else          state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    unique case (state)
      CMD:     if (accept && (in_data == CMD_WRITE_INST || in_data == CMD_WRITE_DATA))
                 next_state = ADDR_LO;
      ADDR_LO: if (accept) next_state = ADDR_HI;
      ADDR_HI: if (accept) next_state = COUNT;
      COUNT:   if (accept) next_state = DATA;
      DATA:    if (accept && idx == LAST_BYTE) next_state = WRITE;
      WRITE:   next_state = (remaining == 9'd1) ? CMD : DATA;
      default: next_state = CMD;
    endcase
  end

  // Command decode, address/count tracking and little-endian word assembly.
  // The selected port's address/data registers are loaded on the last byte so
  // they are valid during WRITE; the other port keeps its previous values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_data         <= 1'b0;
      addr_lo          <= '0;
      addr             <= '0;
      remaining        <= '0;
      shift            <= '0;
      idx              <= '0;
      run              <= 1'b0;
      error            <= 1'b0;
      inst_ext_address <= '0;
      inst_ext_in_data <= '0;
      data_ext_address <= '0;
      data_ext_in_data <= '0;
    end else begin
      unique case (state)
        CMD: if (accept) begin
          unique case (in_data)
            CMD_WRITE_INST: begin sel_data <= 1'b0; run <= 1'b0; end
            CMD_WRITE_DATA: begin sel_data <= 1'b1; run <= 1'b0; end
            CMD_RUN:        run   <= 1'b1;
            CMD_HALT:       run   <= 1'b0;
            default:        error <= 1'b1;
          endcase
        end
        ADDR_LO: if (accept) addr_lo <= in_data;
        ADDR_HI: if (accept) addr <= ADDRESS_WIDTH'({in_data, addr_lo});
        COUNT: if (accept) begin
          remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          idx       <= '0;
        end
        DATA: if (accept) begin
          idx <= idx + 2'd1;
          if (idx == LAST_BYTE) begin
            if (sel_data) begin
              data_ext_address <= addr;
              data_ext_in_data <= WORD_WIDTH'({in_data, shift});
            end else begin
              inst_ext_address <= addr;
              inst_ext_in_data <= WORD_WIDTH'({in_data, shift});
            end
          end else begin
            shift <= {in_data, shift[23:8]};
          end
        end
        WRITE: begin
          addr      <= addr + ADDRESS_WIDTH'(BYTES_PER_WORD);
          remaining <= remaining - 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shader_loader.sv
// Directed bench for shader_loader with a write scoreboard checked by a monitor.
module tb_shader_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] inst_ext_address;
  logic [31:0] inst_ext_in_data;
  logic        inst_ext_write;
  logic [15:0] data_ext_address;
  logic [31:0] data_ext_in_data;
  logic        data_ext_write;
  logic        run;
  logic        busy;
  logic        error;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  typedef struct {
    logic        is_data;
    logic [15:0] addr;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  shader_loader #(.ADDRESS_WIDTH(16), .WORD_WIDTH(32)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .inst_ext_address (inst_ext_address),
    .inst_ext_in_data (inst_ext_in_data),
    .inst_ext_write   (inst_ext_write),
    .data_ext_address (data_ext_address),
    .data_ext_in_data (data_ext_in_data),
    .data_ext_write   (data_ext_write),
    .run              (run),
    .busy             (busy),
    .error            (error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one byte after optional idle cycles; returns #1 after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    logic        rdy;
    int unsigned n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    forever begin
      rdy = in_ready;
      @(posedge clock); #1;
      if (rdy === 1'b1) break;
      n++;
      if (n > 50) begin
        check("xfer_timeout", 32'(rdy), 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  function automatic int unsigned pick_gap(input bit rnd);
    return rnd ? $urandom_range(0, 2) : 0;
  endfunction

  // Send one little-endian word and record the strobe expected right after it.
  task automatic send_word(input bit is_data, input logic [15:0] a, input logic [31:0] w,
                           input bit rnd);
    for (int unsigned k = 0; k < 4; k++) send_byte(w[8*k +: 8], pick_gap(rnd));
    sb.push_back('{is_data, a, w, cyc});
  endtask

  task automatic send_write(input logic [7:0] cmd, input logic [15:0] a, input logic [7:0] cnt,
                            input bit fixed, input logic [31:0] first_word, input bit rnd);
    int unsigned nw;
    logic [15:0] cur;
    logic [31:0] w;
    send_byte(cmd, pick_gap(rnd));
    send_byte(a[7:0], pick_gap(rnd));
    send_byte(a[15:8], pick_gap(rnd));
    send_byte(cnt, pick_gap(rnd));
    nw  = (cnt == 8'd0) ? 256 : int'(cnt);
    cur = a;
    for (int unsigned i = 0; i < nw; i++) begin
      w = (fixed && i == 0) ? first_word : $urandom;
      send_word(cmd == 8'h02, cur, w, rnd);
      cur = cur + 16'd4;
    end
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy !== 1'b0 && n < 100) begin @(posedge clock); #1; n++; end
    check("idle", 32'(busy), 32'd0);
  endtask

  // Monitor: every strobe must match the oldest scoreboard entry
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      check("one_strobe", 32'(inst_ext_write & data_ext_write), 32'd0);
      check("ready_vs_strobe", 32'(in_ready), 32'(!(inst_ext_write | data_ext_write)));
      if (inst_ext_write | data_ext_write) begin
        check("strobe_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("port_sel", 32'(data_ext_write), 32'(mon_e.is_data));
          check("addr", 32'(mon_e.is_data ? data_ext_address : inst_ext_address), 32'(mon_e.addr));
          check("word", mon_e.is_data ? data_ext_in_data : inst_ext_in_data, mon_e.data);
          check("strobe_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("rst_run", 32'(run), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_iaddr", 32'(inst_ext_address), 32'd0);
    check("rst_ddata", data_ext_in_data, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Single instruction word
    send_write(8'h01, 16'h0000, 8'd1, 1'b1, 32'h00A00513, 1'b0);
    wait_idle();
    check("inst_run", 32'(run), 32'd0);

    // Data burst wrapping past 0xFFFC
    send_write(8'h02, 16'hFFF8, 8'd3, 1'b0, 32'h0, 1'b0);
    wait_idle();
    check("hold_iaddr", 32'(inst_ext_address), 32'h0000);
    check("hold_idata", inst_ext_in_data, 32'h00A00513);
    check("wrap_daddr", 32'(data_ext_address), 32'h0000);

    // Count 0 means 256 words
    send_write(8'h01, 16'h1000, 8'd0, 1'b0, 32'h0, 1'b0);
    wait_idle();
    check("cnt0_last_addr", 32'(inst_ext_address), 32'h13FC);

    // Run control
    send_byte(8'h03, 0);
    check("run_on", 32'(run), 32'd1);
    send_byte(8'h01, 0);
    check("run_off_on_write", 32'(run), 32'd0);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(1'b0, 16'h0004, 32'hDEADBEEF, 1'b0);
    wait_idle();
    send_byte(8'h04, 0);
    check("halt_run", 32'(run), 32'd0);

    // Unknown command then a stalled write
    send_byte(8'h7F, 0);
    check("err_set", 32'(error), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    send_write(8'h02, 16'h0020, 8'd2, 1'b0, 32'h0, 1'b1);
    wait_idle();
    check("err_sticky", 32'(error), 32'd1);

    // Reset mid-packet after two data bytes
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_ready", 32'(in_ready), 32'd1);
    check("mid_error", 32'(error), 32'd0);
    check("mid_istrobe", 32'(inst_ext_write), 32'd0);
    check("mid_iaddr", 32'(inst_ext_address), 32'd0);
    check("mid_idata", inst_ext_in_data, 32'd0);
    check("mid_daddr", 32'(data_ext_address), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    send_write(8'h01, 16'h0000, 8'd1, 1'b1, 32'hCAFEF00D, 1'b0);
    wait_idle();
    repeat (3) @(posedge clock);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
